sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's fixed 8-bit synchronous FIFO. It adds configurable width and depth, programmable almost-full and almost-empty thresholds, an occupancy count, and overflow/underflow error pulses. It also offers a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer in the same clock domain and is used as the generic buffering primitive across the design.

---
 rtl/sync_fifo_param.sv | 78 +++++++
 tb/tb_sync_fifo_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/empty thresholds,
// occupancy count, overflow/underflow pulses and optional first-word-fall-through read.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [WIDTH-1:0]  din,
  input  logic              rd,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W-1:0] wrptr,
  output logic [ADDR_W-1:0] rdptr
);

  localparam int CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO is still accepted when a read frees the slot in the same cycle.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || rd);

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

  always_ff @(posedge clk) begin
    if (do_wr) mem[wrptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrptr     <= '0;
      rdptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_wr) wrptr <= wrptr + ADDR_W'(1);
      if (do_rd) rdptr <= rdptr + ADDR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      overflow  <= wr && full && !rd;
      underflow <= rd && empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout = mem[rdptr];
    end else begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        dout <= '0;
        else if (do_rd) dout <= mem[rdptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a registered-read instance and an FWFT instance.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr, rd, wr1, rd1;
  logic [7:0] din, din1;
  logic [7:0] dout, dout1;
  logic       full, empty, afull, aempty, ovf, unf;
  logic       full1, empty1, afull1, aempty1, ovf1, unf1;
  logic [4:0] count, count1;
  logic [3:0] wrptr, rdptr, wrptr1, rdptr1;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .rd(rd), .dout(dout),
    .full(full), .empty(empty), .almost_full(afull), .almost_empty(aempty),
    .count(count), .overflow(ovf), .underflow(unf), .wrptr(wrptr), .rdptr(rdptr)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .wr(wr1), .din(din1), .rd(rd1), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(afull1), .almost_empty(aempty1),
    .count(count1), .overflow(ovf1), .underflow(unf1), .wrptr(wrptr1), .rdptr(rdptr1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr = 0; rd = 0; din = '0; wr1 = 0; rd1 = 0; din1 = '0;
    tick(); tick();
    tests++;
    if ({count, empty, full, aempty, afull, ovf, unf} !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_flags: got cnt=%0d e=%b f=%b ae=%b af=%b o=%b u=%b expected cnt=0 e=1 f=0 ae=1 af=0 o=0 u=0",
                        count, empty, full, aempty, afull, ovf, unf);
    end
    tests++;
    if ({wrptr, rdptr, dout} !== 16'h0000) begin
      fails++; $display("FAIL reset_ptrs: got wr=%0d rd=%0d dout=%0h expected 0 0 0", wrptr, rdptr, dout);
    end
    tests++;
    if ({count1, empty1, wrptr1, rdptr1} !== {5'd0, 1'b1, 4'd0, 4'd0}) begin
      fails++; $display("FAIL reset_fwft: got cnt=%0d e=%b wr=%0d rd=%0d expected 0 1 0 0", count1, empty1, wrptr1, rdptr1);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; din = 8'(i);
      tick();
      tests++;
      if (count !== 5'(i)) begin
        fails++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i);
      end
      tests++;
      if (afull !== (i >= 14)) begin
        fails++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, afull, (i >= 14));
      end
      tests++;
      if (aempty !== (i <= 2)) begin
        fails++; $display("FAIL fill_aempty[%0d]: got %b expected %b", i, aempty, (i <= 2));
      end
    end
    wr = 1'b0;
    tests++;
    if ({full, empty, wrptr, rdptr} !== {1'b1, 1'b0, 4'd0, 4'd0}) begin
      fails++; $display("FAIL fill_full: got f=%b e=%b wr=%0d rd=%0d expected 1 0 0 0", full, empty, wrptr, rdptr);
    end
  endtask

  task automatic test_overflow();
    wr = 1'b1; din = 8'hAA;
    tick();
    wr = 1'b0;
    tests++;
    if ({ovf, count, wrptr} !== {1'b1, 5'd16, 4'd0}) begin
      fails++; $display("FAIL overflow_pulse: got o=%b cnt=%0d wr=%0d expected 1 16 0", ovf, count, wrptr);
    end
    tick();
    tests++;
    if (ovf !== 1'b0) begin
      fails++; $display("FAIL overflow_clear: got %b expected 0", ovf);
    end
  endtask

  task automatic test_full_rdwr();
    wr = 1'b1; rd = 1'b1; din = 8'h55;
    tick();
    wr = 1'b0;
    tests++;
    if ({dout, count, ovf} !== {8'h01, 5'd16, 1'b0}) begin
      fails++; $display("FAIL full_rdwr: got dout=%0h cnt=%0d o=%b expected 01 16 0", dout, count, ovf);
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      tests++;
      if (dout !== ((i == 16) ? 8'h55 : 8'(i + 1))) begin
        fails++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, dout, ((i == 16) ? 8'h55 : 8'(i + 1)));
      end
    end
    rd = 1'b0;
    tests++;
    if ({count, empty, rdptr, wrptr} !== {5'd0, 1'b1, 4'd1, 4'd1}) begin
      fails++; $display("FAIL drain_end: got cnt=%0d e=%b rd=%0d wr=%0d expected 0 1 1 1", count, empty, rdptr, wrptr);
    end
  endtask

  task automatic test_underflow();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    tests++;
    if ({unf, dout, count, rdptr} !== {1'b1, 8'h55, 5'd0, 4'd1}) begin
      fails++; $display("FAIL underflow_pulse: got u=%b dout=%0h cnt=%0d rd=%0d expected 1 55 0 1", unf, dout, count, rdptr);
    end
    tick();
    tests++;
    if (unf !== 1'b0) begin
      fails++; $display("FAIL underflow_clear: got %b expected 0", unf);
    end
    wr = 1'b1; rd = 1'b1; din = 8'h3C;
    tick();
    wr = 1'b0;
    tests++;
    if ({unf, count, dout} !== {1'b1, 5'd1, 8'h55}) begin
      fails++; $display("FAIL empty_rdwr: got u=%b cnt=%0d dout=%0h expected 1 1 55", unf, count, dout);
    end
    tick();
    rd = 1'b0;
    tests++;
    if ({dout, count, unf} !== {8'h3C, 5'd0, 1'b0}) begin
      fails++; $display("FAIL empty_rdwr_read: got dout=%0h cnt=%0d u=%b expected 3c 0 0", dout, count, unf);
    end
  endtask

  task automatic test_fwft();
    wr1 = 1'b1; din1 = 8'h77;
    tick();
    tests++;
    if ({dout1, empty1, count1} !== {8'h77, 1'b0, 5'd1}) begin
      fails++; $display("FAIL fwft_first: got dout=%0h e=%b cnt=%0d expected 77 0 1", dout1, empty1, count1);
    end
    din1 = 8'h88;
    tick();
    wr1 = 1'b0;
    tests++;
    if ({dout1, count1} !== {8'h77, 5'd2}) begin
      fails++; $display("FAIL fwft_hold: got dout=%0h cnt=%0d expected 77 2", dout1, count1);
    end
    rd1 = 1'b1;
    tick();
    tests++;
    if ({dout1, count1} !== {8'h88, 5'd1}) begin
      fails++; $display("FAIL fwft_advance: got dout=%0h cnt=%0d expected 88 1", dout1, count1);
    end
    tick();
    rd1 = 1'b0;
    tests++;
    if ({empty1, count1, unf1} !== {1'b1, 5'd0, 1'b0}) begin
      fails++; $display("FAIL fwft_empty: got e=%b cnt=%0d u=%b expected 1 0 0", empty1, count1, unf1);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; din = 8'hE0 + 8'(i);
      tick();
    end
    tests++;
    if (count !== 5'd5) begin
      fails++; $display("FAIL midburst_count: got %0d expected 5", count);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({count, empty, wrptr, rdptr} !== {5'd0, 1'b1, 4'd0, 4'd0}) begin
      fails++; $display("FAIL async_reset: got cnt=%0d e=%b wr=%0d rd=%0d expected 0 1 0 0", count, empty, wrptr, rdptr);
    end
    wr = 1'b0;
    tick();
    rst = 1'b0;
    wr = 1'b1; din = 8'h99;
    tick();
    wr = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    tests++;
    if ({dout, count, rdptr} !== {8'h99, 5'd0, 4'd1}) begin
      fails++; $display("FAIL post_reset_rw: got dout=%0h cnt=%0d rd=%0d expected 99 0 1", dout, count, rdptr);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_full_rdwr();
    test_underflow();
    test_fwft();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
